// File: rtl/out_sig_collector.sv
// Per-run MISR signature collector for the reduced output nibble stream.
// Optional OUT_SIG_STRAY_CHECK_EN enables sticky detection of beats arriving while idle.
module out_sig_collector #(
    parameter int                   DIN_WIDTH    = 4,
    parameter int                   SIG_WIDTH    = 16,
    parameter int                   CNT_WIDTH    = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY     = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SIG_SEED     = 16'hFFFF,
    parameter int                   DRAIN_CYCLES = 3
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    input  logic                 ap_done,
    input  logic                 data_valid_in,
    input  logic [DIN_WIDTH-1:0] data_in,
    output logic [SIG_WIDTH-1:0] sig_out,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic [CNT_WIDTH-1:0] run_count,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 stray_err
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DW-1:0]        drain_q;
    logic [SIG_WIDTH-1:0] sig_out_q;
    logic [CNT_WIDTH-1:0] beat_count_q;
    logic [CNT_WIDTH-1:0] run_count_q;
    logic                 result_valid_q;
    logic                 busy_q;

    // Accumulator value including the current cycle's beat, if any.
    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (data_valid_in) begin
            sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0}
                  ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0)
                  ^ SIG_WIDTH'(data_in);
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q        <= ST_IDLE;
            sig_q          <= SIG_SEED;
            cnt_q          <= '0;
            drain_q        <= '0;
            sig_out_q      <= '0;
            beat_count_q   <= '0;
            run_count_q    <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ap_start) begin
                        sig_q   <= SIG_SEED;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sig_q <= sig_d;
                    cnt_q <= cnt_d;
                    if (ap_done) begin
                        if (DRAIN_CYCLES == 0) begin
                            sig_out_q      <= sig_d;
                            beat_count_q   <= cnt_d;
                            run_count_q    <= run_count_q + CNT_WIDTH'(1);
                            result_valid_q <= 1'b1;
                            state_q        <= ST_IDLE;
                            busy_q         <= 1'b0;
                        end else begin
                            drain_q <= DW'(DRAIN_CYCLES);
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    sig_q   <= sig_d;
                    cnt_q   <= cnt_d;
                    drain_q <= drain_q - DW'(1);
                    if (drain_q == DW'(1)) begin
                        sig_out_q      <= sig_d;
                        beat_count_q   <= cnt_d;
                        run_count_q    <= run_count_q + CNT_WIDTH'(1);
                        result_valid_q <= 1'b1;
                        state_q        <= ST_IDLE;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef OUT_SIG_STRAY_CHECK_EN
    logic stray_q;

    // Stray beats only raise the flag; the accumulator ignores them in IDLE.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stray_q <= 1'b0;
        end else if (state_q == ST_IDLE && data_valid_in) begin
            stray_q <= 1'b1;
        end
    end

    assign stray_err = stray_q;
`else
    assign stray_err = 1'b0;
`endif

    assign sig_out      = sig_out_q;
    assign beat_count   = beat_count_q;
    assign run_count    = run_count_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_out_sig_collector.sv
// Scoreboard bench for out_sig_collector: expected per-run results are queued at ap_done
// and compared when result_valid pulses.
module tb_out_sig_collector;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        data_valid_in;
    logic [3:0]  data_in;
    logic [15:0] sig_out;
    logic [15:0] beat_count;
    logic [15:0] run_count;
    logic        result_valid;
    logic        busy;
    logic        stray_err;

    out_sig_collector dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .data_valid_in (data_valid_in),
        .data_in       (data_in),
        .sig_out       (sig_out),
        .beat_count    (beat_count),
        .run_count     (run_count),
        .result_valid  (result_valid),
        .busy          (busy),
        .stray_err     (stray_err)
    );

    always #5 ap_clk = ~ap_clk;

`ifdef OUT_SIG_STRAY_CHECK_EN
    localparam logic STRAY_EXP = 1'b1;
`else
    localparam logic STRAY_EXP = 1'b0;
`endif

    typedef struct {
        logic [15:0] sig;
        logic [15:0] cnt;
        logic [15:0] runs;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          results_seen = 0;
    logic [15:0] exp_runs = '0;
    logic        busy_s;
    logic        prev_rv = 1'b0;

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, d};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; busy is sampled mid-cycle.
    task automatic step(input logic s, input logic d, input logic v, input logic [3:0] x);
        ap_start      = s;
        ap_done       = d;
        data_valid_in = v;
        data_in       = x;
        @(negedge ap_clk);
        busy_s = busy;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] sig, input logic [15:0] cnt);
        exp_t e;
        exp_runs = exp_runs + 16'd1;
        e.sig  = sig;
        e.cnt  = cnt;
        e.runs = exp_runs;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        ap_rst = 1'b1;
        ap_start = 0; ap_done = 0; data_valid_in = 0; data_in = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst   = 1'b0;
        exp_runs = '0;
        sb.delete();
    endtask

    task automatic do_run(input int nb, input int gap);
        logic [15:0] s;
        logic [15:0] c;
        logic [3:0]  x;
        s = 16'hFFFF;
        c = '0;
        step(1, 0, 0, 0);
        for (int i = 0; i < nb; i++) begin
            x = 4'($urandom_range(0, 15));
            s = misr(s, x);
            c = c + 16'd1;
            step(0, 0, 1, x);
        end
        repeat (gap) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        push_exp(s, c);
        step(0, 0, 0, 0);
        check_eq("busy_drain", busy_s, 1);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("busy_after", busy_s, 0);
    endtask

    always @(negedge ap_clk) begin
        exp_t e;
        if (result_valid) begin
            results_seen++;
            check_eq("rv_pulse", prev_rv, 0);
            if (sb.size() == 0) begin
                check_eq("rv_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("sig_out", sig_out, e.sig);
                check_eq("beat_count", beat_count, e.cnt);
                check_eq("run_count", run_count, e.runs);
            end
        end
        prev_rv = result_valid;
    end

    initial begin
        logic [15:0] s3;
        logic [3:0]  x;
        int          seen0;

        ap_rst = 1'b1;
        ap_start = 0; ap_done = 0; data_valid_in = 0; data_in = '0;
        #1;
        check_eq("rst_sig", sig_out, 0);
        check_eq("rst_cnt", beat_count, 0);
        check_eq("rst_runs", run_count, 0);
        check_eq("rst_rv", result_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_stray", stray_err, 0);
        apply_reset();

        // Empty run, ap_done 5 cycles after start.
        do_run(0, 4);
        check_eq("t1_sig", sig_out, 16'hFFFF);
        check_eq("t1_cnt", beat_count, 0);
        check_eq("t1_runs", run_count, 1);

        // Single beat of 4'hA.
        step(1, 0, 0, 0);
        step(0, 0, 1, 4'hA);
        step(0, 1, 0, 0);
        push_exp(16'hEFD5, 16'd1);
        repeat (4) step(0, 0, 0, 0);
        check_eq("t2_sig", sig_out, 16'hEFD5);
        check_eq("t2_cnt", beat_count, 1);

        // Beat on the last drain cycle counts; the one after it does not.
        s3 = misr(misr(16'hFFFF, 4'h5), 4'h3);
        step(1, 0, 0, 0);
        step(0, 0, 1, 4'h5);
        step(0, 1, 0, 0);
        push_exp(s3, 16'd2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 4'h3);
        step(0, 0, 1, 4'h7);
        step(0, 0, 0, 0);
        check_eq("t3_cnt", beat_count, 2);
        check_eq("t3_sig", sig_out, s3);
        check_eq("t3_stray", stray_err, STRAY_EXP);

        // Stray flag is sticky across a normal run.
        do_run(5, 0);
        check_eq("t6_stray_hold", stray_err, STRAY_EXP);

        // Reset mid-run discards everything asynchronously.
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 4'($urandom_range(0, 15)));
        #2;
        ap_rst = 1'b1;
        #1;
        check_eq("t5_sig", sig_out, 0);
        check_eq("t5_cnt", beat_count, 0);
        check_eq("t5_runs", run_count, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_rv", result_valid, 0);
        check_eq("t5_stray", stray_err, 0);
        check_eq("t5_sb_empty", sb.size(), 0);
        @(posedge ap_clk);
        #1;
        apply_reset();
        do_run(3, 1);
        check_eq("t5_new_cnt", beat_count, 3);
        check_eq("t5_new_runs", run_count, 1);

        // Back-to-back runs with ap_start held high.
        apply_reset();
        seen0 = results_seen;
        for (int r = 0; r < 3; r++) begin
            logic [15:0] s;
            s = 16'hFFFF;
            step(1, 0, 0, 0);
            check_eq("t4_idle_gap", busy_s, 0);
            for (int i = 0; i < 64; i++) begin
                x = 4'($urandom_range(0, 15));
                s = misr(s, x);
                step(1, 0, 1, x);
                if (i == 0) check_eq("t4_busy_run", busy_s, 1);
            end
            step(1, 1, 0, 0);
            push_exp(s, 16'd64);
            repeat (3) begin
                step(1, 0, 0, 0);
                check_eq("t4_busy_drain", busy_s, 1);
            end
        end
        step(0, 0, 0, 0);
        check_eq("t4_busy_end", busy_s, 0);
        step(0, 0, 0, 0);
        check_eq("t4_pulses", results_seen - seen0, 3);
        check_eq("t4_cnt", beat_count, 64);
        check_eq("t4_runs", run_count, 3);
        check_eq("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
